// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS control sequencer: walks each instruction through fetch/decode/
// execute/writeback, stalls on memory, counts retirements and latches a halt.
module mips_state_sequencer #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count,
  output logic               halted
);

  typedef enum logic [3:0] {
    FETCH            = 4'd0,
    READ_FROM_MEMORY = 4'd1,
    DECODE           = 4'd2,
    EXECUTE          = 4'd3,
    ALU_WRITEBACK    = 4'd4,
    MEM_ADDR         = 4'd5,
    MEM_READ         = 4'd6,
    MEM_WRITEBACK    = 4'd7,
    MEM_WRITE        = 4'd8,
    BRANCH           = 4'd9,
    JUMP             = 4'd10,
    ADDI_EXECUTE     = 4'd11,
    ADDI_WRITEBACK   = 4'd12,
    HALT             = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_t cur;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= FETCH;
      instr_done  <= 1'b0;
      instr_count <= '0;
      halted      <= 1'b0;
    end else if (ena) begin
      instr_done <= 1'b0;
      case (cur)
        FETCH:            cur <= READ_FROM_MEMORY;
        READ_FROM_MEMORY: if (mem_ready) cur <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:      cur <= EXECUTE;
            OP_LW, OP_SW:  cur <= MEM_ADDR;
            OP_BEQ:        cur <= BRANCH;
            OP_J:          cur <= JUMP;
            OP_ADDI:       cur <= ADDI_EXECUTE;
            default: begin
              cur    <= HALT;
              halted <= 1'b1;
            end
          endcase
        end
        EXECUTE:      cur <= ALU_WRITEBACK;
        ADDI_EXECUTE: cur <= ADDI_WRITEBACK;
        MEM_ADDR:     cur <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ:     if (mem_ready) cur <= MEM_WRITEBACK;
        MEM_WRITE: begin
          if (mem_ready) begin
            cur         <= FETCH;
            instr_count <= instr_count + COUNT_W'(1);
            instr_done  <= 1'b1;
          end
        end
        ALU_WRITEBACK, MEM_WRITEBACK, ADDI_WRITEBACK, BRANCH, JUMP: begin
          cur         <= FETCH;
          instr_count <= instr_count + COUNT_W'(1);
          instr_done  <= 1'b1;
        end
        HALT: cur <= HALT;
        // unused encodings fall into HALT rather than wandering
        default: begin
          cur    <= HALT;
          halted <= 1'b1;
        end
      endcase
    end else begin
      instr_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed-vector bench for mips_state_sequencer; expected results are queued by the
// stimulus and checked by an independent per-cycle monitor.
module tb_mips_state_sequencer;

  logic        clk = 1'b0;
  logic        rst, ena, mem_ready;
  logic [5:0]  opcode;
  logic [3:0]  state, state_w;
  logic        instr_done, instr_done_w;
  logic [31:0] instr_count;
  logic [3:0]  instr_count_w;
  logic        halted, halted_w;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  st;
    logic        done;
    logic [31:0] cnt;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] ex_cnt;
  logic        ex_halt;

  always #5 clk = ~clk;

  mips_state_sequencer #(.COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .mem_ready(mem_ready),
    .state(state), .instr_done(instr_done), .instr_count(instr_count), .halted(halted)
  );

  mips_state_sequencer #(.COUNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .mem_ready(mem_ready),
    .state(state_w), .instr_done(instr_done_w), .instr_count(instr_count_w), .halted(halted_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: one expected record per clock edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state",       32'(state),          32'(e.st));
      check("instr_done",  32'(instr_done),     32'(e.done));
      check("instr_count", instr_count,         e.cnt);
      check("halted",      32'(halted),         32'(e.halt));
      check("count_w4",    32'(instr_count_w),  32'(e.cnt[3:0]));
    end
  end

  // drive one cycle; st/done are the hand-computed post-edge values
  task automatic step(input logic r, input logic e, input logic [5:0] op, input logic m,
                      input logic [3:0] st, input logic done);
    exp_t x;
    @(negedge clk);
    rst = r; ena = e; opcode = op; mem_ready = m;
    if (r) begin
      ex_cnt = 0; ex_halt = 1'b0;
    end else begin
      if (done) ex_cnt = ex_cnt + 1;
      if (st == 4'd15) ex_halt = 1'b1;
    end
    x.st = st; x.done = done; x.cnt = ex_cnt; x.halt = ex_halt;
    exp_q.push_back(x);
  endtask

  task automatic run_jump;
    step(0, 1, 6'h02, 1, 4'd1,  0);
    step(0, 1, 6'h02, 1, 4'd2,  0);
    step(0, 1, 6'h02, 1, 4'd10, 0);
    step(0, 1, 6'h02, 1, 4'd0,  1);
  endtask

  initial begin
    rst = 1; ena = 0; opcode = 0; mem_ready = 0;
    ex_cnt = 0; ex_halt = 0;

    step(1, 0, 6'h00, 0, 4'd0, 0);
    step(1, 1, 6'h00, 1, 4'd0, 0);

    // R-type
    step(0, 1, 6'h00, 1, 4'd1, 0);
    step(0, 1, 6'h00, 1, 4'd2, 0);
    step(0, 1, 6'h00, 1, 4'd3, 0);
    step(0, 1, 6'h00, 1, 4'd4, 0);
    step(0, 1, 6'h00, 1, 4'd0, 1);

    // LW with memory waits; mem_ready low in FETCH must not stall
    step(0, 1, 6'h23, 0, 4'd1, 0);
    step(0, 1, 6'h23, 0, 4'd1, 0);
    step(0, 1, 6'h23, 0, 4'd1, 0);
    step(0, 1, 6'h23, 0, 4'd1, 0);
    step(0, 1, 6'h23, 1, 4'd2, 0);
    step(0, 1, 6'h23, 0, 4'd5, 0);
    step(0, 1, 6'h23, 0, 4'd6, 0);
    step(0, 1, 6'h23, 0, 4'd6, 0);
    step(0, 1, 6'h23, 0, 4'd6, 0);
    step(0, 1, 6'h23, 1, 4'd7, 0);
    step(0, 1, 6'h23, 1, 4'd0, 1);

    // SW, including one wait in MEM_WRITE
    step(0, 1, 6'h2B, 1, 4'd1, 0);
    step(0, 1, 6'h2B, 1, 4'd2, 0);
    step(0, 1, 6'h2B, 1, 4'd5, 0);
    step(0, 1, 6'h2B, 1, 4'd8, 0);
    step(0, 1, 6'h2B, 0, 4'd8, 0);
    step(0, 1, 6'h2B, 1, 4'd0, 1);
    // BEQ
    step(0, 1, 6'h04, 1, 4'd1, 0);
    step(0, 1, 6'h04, 1, 4'd2, 0);
    step(0, 1, 6'h04, 0, 4'd9, 0);
    step(0, 1, 6'h04, 0, 4'd0, 1);
    // J
    run_jump();
    // ADDI
    step(0, 1, 6'h08, 1, 4'd1,  0);
    step(0, 1, 6'h08, 1, 4'd2,  0);
    step(0, 1, 6'h08, 1, 4'd11, 0);
    step(0, 1, 6'h08, 1, 4'd12, 0);
    step(0, 1, 6'h08, 1, 4'd0,  1);

    // stall in EXECUTE
    step(0, 1, 6'h00, 1, 4'd1, 0);
    step(0, 1, 6'h00, 1, 4'd2, 0);
    step(0, 1, 6'h00, 1, 4'd3, 0);
    step(0, 0, 6'h00, 1, 4'd3, 0);
    step(0, 0, 6'h23, 0, 4'd3, 0);
    step(0, 0, 6'h00, 1, 4'd3, 0);
    step(0, 1, 6'h00, 1, 4'd4, 0);
    step(0, 0, 6'h00, 1, 4'd4, 0);
    step(0, 1, 6'h00, 1, 4'd0, 1);
    step(0, 0, 6'h00, 1, 4'd0, 0);

    // unsupported opcode -> HALT, sticky
    step(0, 1, 6'h3F, 1, 4'd1,  0);
    step(0, 1, 6'h3F, 1, 4'd2,  0);
    step(0, 1, 6'h3F, 1, 4'd15, 0);
    step(0, 0, 6'h00, 0, 4'd15, 0);
    step(0, 1, 6'h00, 1, 4'd15, 0);
    step(0, 1, 6'h23, 0, 4'd15, 0);
    step(1, 0, 6'h00, 0, 4'd0,  0);

    // 17 retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) run_jump();

    // reset in MEM_READ abandons the LW
    step(0, 1, 6'h23, 1, 4'd1, 0);
    step(0, 1, 6'h23, 1, 4'd2, 0);
    step(0, 1, 6'h23, 1, 4'd5, 0);
    step(0, 1, 6'h23, 0, 4'd6, 0);
    step(1, 1, 6'h23, 1, 4'd0, 0);
    step(0, 1, 6'h00, 1, 4'd1, 0);

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
